pong_game_engine: RTL and testbench

//  Parametrised ball/paddle/score engine for the VGA pong design. Per frame tick it moves the ball and

---
 rtl/pong_game_engine_pkg.sv | 30 +++
 rtl/pong_game_engine_if.sv | 30 +++
 rtl/pong_game_engine_paddle_collide.sv | 42 ++++
 rtl/pong_game_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/pong_game_engine_pkg.sv
// Shared state codes, hit-zone codes and default geometry for the pong engine.
package pong_game_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ZONE_CENTRE = 2'd0,
        ZONE_TOP    = 2'd1,
        ZONE_BOTTOM = 2'd2
    } zone_t;

    localparam int SCREEN_W_D    = 640;
    localparam int SCREEN_H_D    = 480;
    localparam int BALL_SIZE_D   = 10;
    localparam int PADDLE_W_D    = 10;
    localparam int PADDLE_H_D    = 50;
    localparam int LEFT_PAD_X_D  = 40;
    localparam int RIGHT_PAD_X_D = 600;
    localparam int SPEED_INIT_D  = 2;
    localparam int SPEED_MAX_D   = 6;
    localparam int WIN_SCORE_D   = 9;
    localparam int SERVE_TICKS_D = 60;

endpackage

// File: rtl/pong_game_engine_if.sv
// Frame-rate control inputs and ball/paddle/score outputs of the pong engine.
interface pong_game_engine_if;
    logic        tick;
    logic        start;
    logic [9:0]  pad_l_y;
    logic [9:0]  pad_r_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [9:0]  pad_l_y_q;
    logic [9:0]  pad_r_y_q;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        point_l;
    logic        point_r;
    logic        game_over;
    logic        winner;
    logic [2:0]  state_o;

    modport master (
        output tick, start, pad_l_y, pad_r_y,
        input  ball_x, ball_y, pad_l_y_q, pad_r_y_q, score_l, score_r,
               point_l, point_r, game_over, winner, state_o
    );

    modport slave (
        input  tick, start, pad_l_y, pad_r_y,
        output ball_x, ball_y, pad_l_y_q, pad_r_y_q, score_l, score_r,
               point_l, point_r, game_over, winner, state_o
    );
endinterface

// File: rtl/pong_game_engine_paddle_collide.sv
// Combinational paddle test: edge crossing this tick, Y overlap, and which third of the paddle was hit.
module pong_game_engine_paddle_collide
    import pong_game_engine_pkg::*;
#(
    parameter bit IS_LEFT   = 1'b1,
    parameter int EDGE_X    = 50,
    parameter int BALL_SIZE = BALL_SIZE_D,
    parameter int PADDLE_H  = PADDLE_H_D
) (
    input  logic               toward,
    input  logic signed [11:0] p_x,
    input  logic signed [11:0] nx,
    input  logic signed [11:0] ny,
    input  logic [9:0]         pad_y,
    output logic               hit,
    output zone_t              zone
);
    localparam logic signed [11:0] EDGE      = 12'(EDGE_X);
    localparam logic signed [11:0] BSZ       = 12'(BALL_SIZE);
    localparam logic signed [11:0] HALF      = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] PH        = 12'(PADDLE_H);
    localparam logic signed [11:0] THIRD     = 12'(PADDLE_H / 3);
    localparam logic signed [11:0] TWO_THIRD = 12'((2 * PADDLE_H) / 3);

    logic signed [11:0] pad_s;
    logic signed [11:0] off;
    logic               crossed;
    logic               overlap;

    always_comb begin
        pad_s = $signed({2'b00, pad_y});
        if (IS_LEFT) crossed = (p_x >= EDGE) && (nx <= EDGE);
        else         crossed = (p_x <= EDGE) && (nx >= EDGE);
        overlap = ((ny + BSZ) > pad_s) && (ny < (pad_s + PH));
        hit     = toward && crossed && overlap;
        // zone from ball centre relative to paddle top; above the paddle counts as top
        off = ny + HALF - pad_s;
        if (off < THIRD)           zone = ZONE_TOP;
        else if (off >= TWO_THIRD) zone = ZONE_BOTTOM;
        else                       zone = ZONE_CENTRE;
    end
endmodule

// File: rtl/pong_game_engine.sv
// Ball/paddle/score engine: moves the ball once per frame tick, bounces it and sequences serve/point/game-over.
// state     | meaning
// IDLE      | after reset, ball centred, waiting for start
// SERVE     | ball held centred for SERVE_TICKS ticks
// PLAY      | ball moving, walls and paddles reflect it
// POINT     | one tick: score, pulse, recentre
// GAME_OVER | winner shown, waiting for start
module pong_game_engine
    import pong_game_engine_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_D,
    parameter int SCREEN_H    = SCREEN_H_D,
    parameter int BALL_SIZE   = BALL_SIZE_D,
    parameter int PADDLE_W    = PADDLE_W_D,
    parameter int PADDLE_H    = PADDLE_H_D,
    parameter int LEFT_PAD_X  = LEFT_PAD_X_D,
    parameter int RIGHT_PAD_X = RIGHT_PAD_X_D,
    parameter int SPEED_INIT  = SPEED_INIT_D,
    parameter int SPEED_MAX   = SPEED_MAX_D,
    parameter int WIN_SCORE   = WIN_SCORE_D,
    parameter int SERVE_TICKS = SERVE_TICKS_D
) (
    input logic              clk,
    input logic              reset_n,
    pong_game_engine_if.slave bus
);
    localparam int CNT_W  = $clog2(SERVE_TICKS + 1);
    localparam int L_EDGE = LEFT_PAD_X + PADDLE_W;
    localparam int R_EDGE = RIGHT_PAD_X - BALL_SIZE;

    localparam logic [10:0]        X_CENTRE   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         Y_CENTRE   = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0]        X_L_EDGE   = 11'(L_EDGE);
    localparam logic [10:0]        X_R_EDGE   = 11'(R_EDGE);
    localparam logic [10:0]        X_MAX      = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] X_MAX_S    = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]         Y_MAX      = 10'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX_S    = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         PAD_MAX    = 10'(SCREEN_H - PADDLE_H);
    localparam logic [3:0]         S_INIT     = 4'(SPEED_INIT);
    localparam logic [3:0]         SX_MAX     = 4'(SPEED_MAX);
    localparam logic [3:0]         SY_EDGE    = 4'(SPEED_INIT + 1);
    localparam logic [3:0]         SY_CENTRE  = 4'((SPEED_INIT > 1) ? SPEED_INIT - 1 : 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);

    state_t           state;
    logic [10:0]      ball_x;
    logic [9:0]       ball_y;
    logic             dir_left, dir_up;
    logic [3:0]       sx, sy;
    logic [CNT_W-1:0] serve_cnt;
    logic [3:0]       score_l, score_r;
    logic             point_l, point_r, game_over, winner, scored_right;
    logic [9:0]       pad_l_q, pad_r_q;

    logic signed [11:0] px, py, nx, ny;
    logic [9:0]         y_next, pad_l_clamp, pad_r_clamp;
    logic               dir_up_next, hit_l, hit_r;
    logic [3:0]         sx_bump, sy_l, sy_r, score_l_inc, score_r_inc;
    zone_t              zone_l, zone_r;

    always_comb begin
        px = $signed({1'b0, ball_x});
        py = $signed({2'b00, ball_y});
        nx = dir_left ? (px - $signed({8'd0, sx})) : (px + $signed({8'd0, sx}));
        ny = dir_up   ? (py - $signed({8'd0, sy})) : (py + $signed({8'd0, sy}));
        y_next      = ny[9:0];
        dir_up_next = dir_up;
        if (ny <= 12'sd0) begin
            y_next      = '0;
            dir_up_next = 1'b0;
        end else if (ny >= Y_MAX_S) begin
            y_next      = Y_MAX;
            dir_up_next = 1'b1;
        end
        sx_bump     = (sx >= SX_MAX) ? SX_MAX : sx + 4'd1;
        sy_l        = (zone_l == ZONE_CENTRE) ? SY_CENTRE : SY_EDGE;
        sy_r        = (zone_r == ZONE_CENTRE) ? SY_CENTRE : SY_EDGE;
        score_l_inc = (score_l >= WIN) ? WIN : score_l + 4'd1;
        score_r_inc = (score_r >= WIN) ? WIN : score_r + 4'd1;
        pad_l_clamp = (bus.pad_l_y > PAD_MAX) ? PAD_MAX : bus.pad_l_y;
        pad_r_clamp = (bus.pad_r_y > PAD_MAX) ? PAD_MAX : bus.pad_r_y;
    end

    pong_game_engine_paddle_collide #(
        .IS_LEFT(1'b1), .EDGE_X(L_EDGE), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)
    ) u_collide_l (
        .toward(dir_left), .p_x(px), .nx(nx), .ny(ny), .pad_y(pad_l_q),
        .hit(hit_l), .zone(zone_l)
    );

    pong_game_engine_paddle_collide #(
        .IS_LEFT(1'b0), .EDGE_X(R_EDGE), .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)
    ) u_collide_r (
        .toward(~dir_left), .p_x(px), .nx(nx), .ny(ny), .pad_y(pad_r_q),
        .hit(hit_r), .zone(zone_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ball_x       <= X_CENTRE;
            ball_y       <= Y_CENTRE;
            dir_left     <= 1'b0;
            dir_up       <= 1'b0;
            sx           <= S_INIT;
            sy           <= S_INIT;
            serve_cnt    <= SERVE_LOAD;
            score_l      <= '0;
            score_r      <= '0;
            point_l      <= 1'b0;
            point_r      <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            scored_right <= 1'b0;
            pad_l_q      <= '0;
            pad_r_q      <= '0;
        end else begin
            point_l <= 1'b0;
            point_r <= 1'b0;
            if (bus.tick) begin
                pad_l_q <= pad_l_clamp;
                pad_r_q <= pad_r_clamp;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_SERVE;
                        serve_cnt <= SERVE_LOAD;
                        ball_x    <= X_CENTRE;
                        ball_y    <= Y_CENTRE;
                        dir_up    <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (bus.tick) begin
                        if (serve_cnt == '0) begin
                            state <= ST_PLAY;
                            sx    <= S_INIT;
                            sy    <= S_INIT;
                        end else begin
                            serve_cnt <= serve_cnt - 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.tick) begin
                        ball_y <= y_next;
                        dir_up <= dir_up_next;
                        // paddle reflection wins over a miss in the same tick
                        if (hit_l) begin
                            ball_x   <= X_L_EDGE;
                            dir_left <= 1'b0;
                            sx       <= sx_bump;
                            sy       <= sy_l;
                        end else if (hit_r) begin
                            ball_x   <= X_R_EDGE;
                            dir_left <= 1'b1;
                            sx       <= sx_bump;
                            sy       <= sy_r;
                        end else if (nx <= 12'sd0) begin
                            ball_x       <= '0;
                            scored_right <= 1'b1;
                            state        <= ST_POINT;
                        end else if (nx >= X_MAX_S) begin
                            ball_x       <= X_MAX;
                            scored_right <= 1'b0;
                            state        <= ST_POINT;
                        end else begin
                            ball_x <= nx[10:0];
                        end
                    end
                end
                ST_POINT: begin
                    if (bus.tick) begin
                        ball_x    <= X_CENTRE;
                        ball_y    <= Y_CENTRE;
                        dir_up    <= 1'b0;
                        serve_cnt <= SERVE_LOAD;
                        // next serve heads toward whoever conceded
                        dir_left  <= scored_right;
                        if (scored_right) begin
                            score_r <= score_r_inc;
                            point_r <= 1'b1;
                        end else begin
                            score_l <= score_l_inc;
                            point_l <= 1'b1;
                        end
                        if ((scored_right ? score_r_inc : score_l_inc) == WIN) begin
                            state     <= ST_GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= scored_right;
                        end else begin
                            state <= ST_SERVE;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (bus.start) begin
                        state     <= ST_SERVE;
                        game_over <= 1'b0;
                        score_l   <= '0;
                        score_r   <= '0;
                        serve_cnt <= SERVE_LOAD;
                        ball_x    <= X_CENTRE;
                        ball_y    <= Y_CENTRE;
                        dir_up    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ball_x    = ball_x;
    assign bus.ball_y    = ball_y;
    assign bus.pad_l_y_q = pad_l_q;
    assign bus.pad_r_y_q = pad_r_q;
    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.point_l   = point_l;
    assign bus.point_r   = point_r;
    assign bus.game_over = game_over;
    assign bus.winner    = winner;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: serve timing, walls, paddle hits, scoring and game over.
module tb_pong_game_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    pong_game_engine_if bus();

    pong_game_engine dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // one frame strobe; returns on the falling edge right after the update
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); bus.tick = 1'b1;
            @(negedge clk); bus.tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (bus.state_o !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
        tests_run++; if (bus.ball_x !== 11'd315 || bus.ball_y !== 10'd235) begin tests_failed++; $display("FAIL reset_ball: got (%0d,%0d) expected (315,235)", bus.ball_x, bus.ball_y); end
        tests_run++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin tests_failed++; $display("FAIL reset_score: got %0d/%0d go=%0d w=%0d expected 0/0 0 0", bus.score_l, bus.score_r, bus.game_over, bus.winner); end
        tests_run++; if (bus.pad_l_y_q !== 10'd0 || bus.pad_r_y_q !== 10'd0) begin tests_failed++; $display("FAIL reset_pad: got %0d/%0d expected 0/0", bus.pad_l_y_q, bus.pad_r_y_q); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_serve_to_play();
        pulse_start();
        tests_run++; if (bus.state_o !== 3'd1) begin tests_failed++; $display("FAIL start_to_serve: got %0d expected 1", bus.state_o); end
        tick_n(59);
        tests_run++; if (bus.state_o !== 3'd1 || bus.ball_x !== 11'd315) begin tests_failed++; $display("FAIL serve_hold: got st=%0d x=%0d expected st=1 x=315", bus.state_o, bus.ball_x); end
        tick_n(1);
        tests_run++; if (bus.state_o !== 3'd2 || bus.ball_x !== 11'd315) begin tests_failed++; $display("FAIL serve_to_play: got st=%0d x=%0d expected st=2 x=315", bus.state_o, bus.ball_x); end
        tick_n(1);
        tests_run++; if (bus.ball_x !== 11'd317 || bus.ball_y !== 10'd237) begin tests_failed++; $display("FAIL first_move: got (%0d,%0d) expected (317,237)", bus.ball_x, bus.ball_y); end
        repeat (5) @(negedge clk);
        tests_run++; if (bus.ball_x !== 11'd317) begin tests_failed++; $display("FAIL no_tick_hold: got %0d expected 317", bus.ball_x); end
    endtask

    task automatic test_reset_mid_play();
        tick_n(3);
        tests_run++; if (bus.ball_x !== 11'd323) begin tests_failed++; $display("FAIL play_x: got %0d expected 323", bus.ball_x); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (bus.state_o !== 3'd0 || bus.ball_x !== 11'd315 || bus.ball_y !== 10'd235) begin tests_failed++; $display("FAIL mid_reset: got st=%0d (%0d,%0d) expected st=0 (315,235)", bus.state_o, bus.ball_x, bus.ball_y); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_paddle_clamp();
        bus.pad_l_y = 10'd100;
        bus.pad_r_y = 10'd1000;
        tick_n(1);
        tests_run++; if (bus.pad_l_y_q !== 10'd100 || bus.pad_r_y_q !== 10'd430) begin tests_failed++; $display("FAIL pad_clamp: got %0d/%0d expected 100/430", bus.pad_l_y_q, bus.pad_r_y_q); end
        tests_run++; if (bus.state_o !== 3'd0 || bus.ball_x !== 11'd315) begin tests_failed++; $display("FAIL idle_still: got st=%0d x=%0d expected st=0 x=315", bus.state_o, bus.ball_x); end
    endtask

    task automatic test_right_hit_and_point();
        bus.pad_l_y = 10'd0;
        bus.pad_r_y = 10'd430;
        pulse_start();
        tick_n(60);
        tick_n(118);
        tests_run++; if (bus.ball_y !== 10'd470 || bus.ball_x !== 11'd551) begin tests_failed++; $display("FAIL bottom_wall: got (%0d,%0d) expected (551,470)", bus.ball_x, bus.ball_y); end
        tick_n(19);
        tests_run++; if (bus.ball_x !== 11'd589 || bus.ball_y !== 10'd432) begin tests_failed++; $display("FAIL pre_hit: got (%0d,%0d) expected (589,432)", bus.ball_x, bus.ball_y); end
        tick_n(1);
        tests_run++; if (bus.ball_x !== 11'd590 || bus.ball_y !== 10'd430) begin tests_failed++; $display("FAIL right_hit: got (%0d,%0d) expected (590,430)", bus.ball_x, bus.ball_y); end
        tick_n(1);
        tests_run++; if (bus.ball_x !== 11'd587 || bus.ball_y !== 10'd427) begin tests_failed++; $display("FAIL after_right_hit: got (%0d,%0d) expected (587,427)", bus.ball_x, bus.ball_y); end
        tick_n(143);
        tests_run++; if (bus.ball_y !== 10'd0) begin tests_failed++; $display("FAIL top_wall: got %0d expected 0", bus.ball_y); end
        tick_n(1);
        tests_run++; if (bus.ball_y !== 10'd3) begin tests_failed++; $display("FAIL top_rebound: got %0d expected 3", bus.ball_y); end
        tick_n(52);
        tests_run++; if (bus.state_o !== 3'd3 || bus.ball_x !== 11'd0) begin tests_failed++; $display("FAIL left_miss: got st=%0d x=%0d expected st=3 x=0", bus.state_o, bus.ball_x); end
        tick_n(1);
        tests_run++; if (bus.point_r !== 1'b1 || bus.point_l !== 1'b0) begin tests_failed++; $display("FAIL point_r_pulse: got r=%0d l=%0d expected r=1 l=0", bus.point_r, bus.point_l); end
        tests_run++; if (bus.score_r !== 4'd1 || bus.score_l !== 4'd0 || bus.state_o !== 3'd1) begin tests_failed++; $display("FAIL score_r: got %0d/%0d st=%0d expected l=0 r=1 st=1", bus.score_l, bus.score_r, bus.state_o); end
        @(negedge clk);
        tests_run++; if (bus.point_r !== 1'b0) begin tests_failed++; $display("FAIL point_r_width: got %0d expected 0", bus.point_r); end
    endtask

    task automatic test_serve_left_and_left_hit();
        bus.pad_l_y = 10'd430;
        tick_n(60);
        tests_run++; if (bus.state_o !== 3'd2 || bus.ball_x !== 11'd315) begin tests_failed++; $display("FAIL serve2_play: got st=%0d x=%0d expected st=2 x=315", bus.state_o, bus.ball_x); end
        tick_n(1);
        tests_run++; if (bus.ball_x !== 11'd313 || bus.ball_y !== 10'd237) begin tests_failed++; $display("FAIL serve_left: got (%0d,%0d) expected (313,237)", bus.ball_x, bus.ball_y); end
        tick_n(132);
        tests_run++; if (bus.ball_x !== 11'd50 || bus.ball_y !== 10'd440) begin tests_failed++; $display("FAIL left_hit: got (%0d,%0d) expected (50,440)", bus.ball_x, bus.ball_y); end
        tick_n(1);
        tests_run++; if (bus.ball_x !== 11'd53 || bus.ball_y !== 10'd437) begin tests_failed++; $display("FAIL after_left_hit: got (%0d,%0d) expected (53,437)", bus.ball_x, bus.ball_y); end
    endtask

    task automatic test_game_over();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        bus.pad_l_y = 10'd0;
        bus.pad_r_y = 10'd0;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            tick_n(219);
            tests_run++; if (bus.score_l !== 4'(i) || bus.state_o !== 3'd1) begin tests_failed++; $display("FAIL score_l_step%0d: got %0d st=%0d expected %0d st=1", i, bus.score_l, bus.state_o, i); end
        end
        tests_run++; if (bus.game_over !== 1'b0) begin tests_failed++; $display("FAIL early_game_over: got %0d expected 0", bus.game_over); end
        tick_n(218);
        tests_run++; if (bus.state_o !== 3'd3 || bus.ball_x !== 11'd630) begin tests_failed++; $display("FAIL right_miss: got st=%0d x=%0d expected st=3 x=630", bus.state_o, bus.ball_x); end
        tick_n(1);
        tests_run++; if (bus.score_l !== 4'd9 || bus.point_l !== 1'b1) begin tests_failed++; $display("FAIL final_point: got score=%0d pulse=%0d expected 9 1", bus.score_l, bus.point_l); end
        tests_run++; if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.state_o !== 3'd4) begin tests_failed++; $display("FAIL game_over: got go=%0d w=%0d st=%0d expected 1 0 4", bus.game_over, bus.winner, bus.state_o); end
        tick_n(5);
        tests_run++; if (bus.state_o !== 3'd4 || bus.score_l !== 4'd9) begin tests_failed++; $display("FAIL game_over_hold: got st=%0d score=%0d expected 4 9", bus.state_o, bus.score_l); end
        pulse_start();
        tests_run++; if (bus.state_o !== 3'd1 || bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.game_over !== 1'b0) begin tests_failed++; $display("FAIL restart: got st=%0d %0d/%0d go=%0d expected 1 0/0 0", bus.state_o, bus.score_l, bus.score_r, bus.game_over); end
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.start   = 1'b0;
        bus.pad_l_y = 10'd0;
        bus.pad_r_y = 10'd0;
        test_reset();
        test_serve_to_play();
        test_reset_mid_play();
        test_paddle_clamp();
        test_right_hit_and_point();
        test_serve_left_and_left_hit();
        test_game_over();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
